// File: rtl/instr_fetch_responder.sv
// Fetch-stage responder: one instruction read per fetch strobe, returns the opcode, advances the PC.
// Latency: fetch_start at N -> mem_req at N+1 -> fetch_done at N+2 minimum; every output is registered.
// Backpressure: mem_req/mem_addr are held until mem_ready arrives; fetch_start is ignored while busy.
//
// Ports: control side (fetch_start, pc_load, pc_load_val -> opcode, instr, pc, busy,
//        fetch_done, fetch_err); memory side (mem_req, mem_addr -> mem_rdata, mem_ready).
// Optional feature: define FETCH_TIMEOUT_EN to abort a read after TIMEOUT cycles without
//        mem_ready (fetch_err pulse). When it is undefined, REQ waits forever and fetch_err is 0.
module instr_fetch_responder #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q,  mem_req_d;
    logic [DATA_W-1:0] instr_q,    instr_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    // A pc_load seen mid-fetch is parked here and replaces the increment at completion.
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_val_q, pend_val_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        instr_d    = instr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    if (pc_load) begin
                        // Branch target fetched directly; it supersedes any parked load.
                        mem_addr_d = pc_load_val;
                        pc_d       = pc_load_val;
                        pend_vld_d = 1'b0;
                    end else begin
                        mem_addr_d = pc_q;
                    end
                end else if (pc_load) begin
                    pc_d       = pc_load_val;
                    pend_vld_d = 1'b0;
                end
            end
            REQ: begin
                if (pc_load) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = pc_load_val;
                end
                if (mem_ready) begin
                    instr_d    = mem_rdata;
                    mem_req_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                    pend_vld_d = 1'b0;
                    if (pc_load)
                        pc_d = pc_load_val;
                    else if (pend_vld_q)
                        pc_d = pend_val_q;
                    else
                        pc_d = pc_q + ADDR_W'(PC_STEP);
                end
`ifdef FETCH_TIMEOUT_EN
                // cnt_q counts completed REQ cycles; this is the TIMEOUT-th one.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                // The fetch has already retired, so a load here goes straight to the PC.
                if (pc_load)
                    pc_d = pc_load_val;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            instr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            instr_q    <= instr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign instr      = instr_q;
    assign opcode     = instr_q[DATA_W-1 -: 6];
    assign pc         = pc_q;
    assign busy       = busy_q;
    assign fetch_done = done_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule
